// File: rtl/motion_frame_stats.sv
// Per-frame motion statistics: counts motion pixels, tracks the motion
// bounding box, publishes one result per frame through a valid/ready
// handshake, and runs a hysteresis alarm over consecutive active frames.
module motion_frame_stats #(
    parameter int unsigned IMG_W        = 640,
    parameter int unsigned IMG_H        = 480,
    parameter int unsigned ALARM_FRAMES = 3,
    parameter int unsigned CLEAR_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic        sof,
    input  logic        motion_detected,
    input  logic [18:0] count_thresh,
    input  logic        stats_ready,
    output logic        stats_valid,
    output logic [18:0] motion_count,
    output logic [9:0]  bbox_x_min,
    output logic [9:0]  bbox_x_max,
    output logic [8:0]  bbox_y_min,
    output logic [8:0]  bbox_y_max,
    output logic        bbox_valid,
    output logic        alarm,
    output logic        overrun,
    output logic        sync_err
);

    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned CW    = 19;
    localparam int unsigned RUN_W = $clog2(ALARM_FRAMES + 1);
    localparam int unsigned CLR_W = $clog2(CLEAR_FRAMES + 1);

    localparam logic [XW-1:0]    X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_H - 1);
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(ALARM_FRAMES);
    localparam logic [CLR_W-1:0] CLR_TGT = CLR_W'(CLEAR_FRAMES);

    typedef enum logic {
        IDLE,
        ACCUM
    } frame_state_t;

    typedef enum logic [1:0] {
        QUIET,
        ARMING,
        ALARM
    } alarm_state_t;

    frame_state_t frame_state, frame_next;
    alarm_state_t alarm_state, alarm_next;

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             any_q, any_d;
    logic [XW-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CLR_W-1:0] clr_q, clr_d;

    logic          accept_c;
    logic          start_c;
    logic          frame_done_c;
    logic          sync_err_c;
    logic          active_c;
    logic [XW-1:0] px, b_xmin, b_xmax;
    logic [YW-1:0] py, b_ymin, b_ymax;
    logic [CW-1:0] b_cnt;
    logic          b_any;

    assign accept_c = enable && pix_valid;
    assign start_c  = accept_c && sof;

    // Frame tracking: position counters and per-frame accumulation.
    always_comb begin
        frame_next   = frame_state;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        any_d        = any_q;
        xmin_d       = xmin_q;
        xmax_d       = xmax_q;
        ymin_d       = ymin_q;
        ymax_d       = ymax_q;
        frame_done_c = 1'b0;
        sync_err_c   = 1'b0;

        // A sof pixel starts from a clean slate at the origin.
        if (start_c) begin
            px     = '0;
            py     = '0;
            b_cnt  = '0;
            b_any  = 1'b0;
            b_xmin = '0;
            b_xmax = '0;
            b_ymin = '0;
            b_ymax = '0;
        end else begin
            px     = x_q;
            py     = y_q;
            b_cnt  = cnt_q;
            b_any  = any_q;
            b_xmin = xmin_q;
            b_xmax = xmax_q;
            b_ymin = ymin_q;
            b_ymax = ymax_q;
        end

        if (start_c || (frame_state == ACCUM && accept_c)) begin
            sync_err_c = start_c && (frame_state == ACCUM) &&
                         ((x_q != '0) || (y_q != '0));
            cnt_d  = b_cnt + CW'(motion_detected);
            any_d  = b_any | motion_detected;
            xmin_d = b_xmin;
            xmax_d = b_xmax;
            ymin_d = b_ymin;
            ymax_d = b_ymax;
            if (motion_detected) begin
                if (!b_any) begin
                    xmin_d = px;
                    xmax_d = px;
                    ymin_d = py;
                    ymax_d = py;
                end else begin
                    if (px < b_xmin) xmin_d = px;
                    if (px > b_xmax) xmax_d = px;
                    if (py < b_ymin) ymin_d = py;
                    if (py > b_ymax) ymax_d = py;
                end
            end
            if (px == X_LAST && py == Y_LAST) begin
                frame_done_c = 1'b1;
                frame_next   = IDLE;
                x_d          = '0;
                y_d          = '0;
            end else begin
                frame_next = ACCUM;
                if (px == X_LAST) begin
                    x_d = '0;
                    y_d = py + YW'(1);
                end else begin
                    x_d = px + XW'(1);
                    y_d = py;
                end
            end
        end
    end

    // Alarm hysteresis, advanced only when a frame completes.
    always_comb begin
        alarm_next = alarm_state;
        run_d      = run_q;
        clr_d      = clr_q;
        active_c   = (cnt_d >= count_thresh);
        if (frame_done_c) begin
            case (alarm_state)
                QUIET: begin
                    if (active_c) begin
                        if (RUN_TGT == RUN_W'(1)) begin
                            alarm_next = ALARM;
                            run_d      = '0;
                            clr_d      = '0;
                        end else begin
                            alarm_next = ARMING;
                            run_d      = RUN_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (active_c) begin
                        if (run_q + RUN_W'(1) == RUN_TGT) begin
                            alarm_next = ALARM;
                            run_d      = '0;
                            clr_d      = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        alarm_next = QUIET;
                        run_d      = '0;
                    end
                end
                ALARM: begin
                    if (active_c) begin
                        clr_d = '0;
                    end else if (clr_q + CLR_W'(1) == CLR_TGT) begin
                        alarm_next = QUIET;
                        clr_d      = '0;
                    end else begin
                        clr_d = clr_q + CLR_W'(1);
                    end
                end
                default: begin
                    alarm_next = QUIET;
                    run_d      = '0;
                    clr_d      = '0;
                end
            endcase
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_state <= IDLE;
            alarm_state <= QUIET;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            any_q       <= 1'b0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            run_q       <= '0;
            clr_q       <= '0;
        end else begin
            frame_state <= frame_next;
            alarm_state <= alarm_next;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            any_q       <= any_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            run_q       <= run_d;
            clr_q       <= clr_d;
        end
    end

    // Result registers, handshake, overrun and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            stats_valid  <= 1'b0;
            motion_count <= '0;
            bbox_x_min   <= '0;
            bbox_x_max   <= '0;
            bbox_y_min   <= '0;
            bbox_y_max   <= '0;
            bbox_valid   <= 1'b0;
            alarm        <= 1'b0;
            overrun      <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            sync_err <= sync_err_c;
            alarm    <= (alarm_next == ALARM);
            if (frame_done_c) begin
                stats_valid  <= 1'b1;
                motion_count <= cnt_d;
                bbox_x_min   <= xmin_d;
                bbox_x_max   <= xmax_d;
                bbox_y_min   <= ymin_d;
                bbox_y_max   <= ymax_d;
                bbox_valid   <= any_d;
                if (stats_valid && !stats_ready) overrun <= 1'b1;
            end else if (stats_valid && stats_ready) begin
                stats_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/motion_frame_stats.md
MOTION_FRAME_STATS -- requirements
Module: motion_frame_stats

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have parameter ALARM_FRAMES, default 3, consecutive active frames needed to raise alarm (>=1).
REQ-004 SHALL have parameter CLEAR_FRAMES, default 2, consecutive inactive frames needed to drop alarm (>=1).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enable  input  1  gates pixel acceptance.
REQ-008 SHALL have port pix_valid  input  1  motion_detected is valid this cycle.
REQ-009 SHALL have port sof  input  1  marks the first pixel of a frame; qualified by pix_valid.
REQ-010 SHALL have port motion_detected  input  1  per-pixel motion flag from the sigma-delta update stage.
REQ-011 SHALL have port count_thresh  input  19  per-frame motion-pixel count that makes a frame active.
REQ-012 SHALL have port stats_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port stats_valid  output  1  frame result available.
REQ-014 SHALL have port motion_count  output  19  motion pixels in the last completed frame.
REQ-015 SHALL have ports bbox_x_min and bbox_x_max  output  10 each  motion bounding-box columns.
REQ-016 SHALL have ports bbox_y_min and bbox_y_max  output  9 each  motion bounding-box rows.
REQ-017 SHALL have port bbox_valid  output  1  bounding box holds at least one motion pixel.
REQ-018 SHALL have port alarm  output  1  alarm state.
REQ-019 SHALL have port overrun  output  1  sticky flag: an unread result was overwritten.
REQ-020 SHALL have port sync_err  output  1  one-cycle pulse on a premature sof.

Function
REQ-021 SHALL accept a pixel only when enable && pix_valid; with enable low, all counters, accumulators and FSMs hold.
REQ-022 SHALL use a frame FSM with states IDLE and ACCUM: IDLE ignores accepted pixels without sof; an accepted pixel with sof enters ACCUM at x=0, y=0.
REQ-023 SHALL advance x on each accepted pixel in raster order: x wraps from IMG_W-1 to 0 and increments y.
REQ-024 SHALL initialise count and bbox from the sof pixel itself, discarding prior accumulation.
REQ-025 SHALL, on a motion pixel, increment the count and update the bbox min/max with the current x/y.
REQ-026 SHALL treat sof arriving in ACCUM at a position other than (0,0) as a restart: pulse sync_err, discard the partial frame, and begin a new frame at that pixel.
REQ-027 SHALL complete the frame on the accepted pixel at x=IMG_W-1, y=IMG_H-1, including that pixel, then return to IDLE.
REQ-028 SHALL load the result registers, assert stats_valid, and update alarm on the clock edge after the completing pixel (latency 1).
REQ-029 SHALL, when a frame has no motion pixels, output bbox_valid=0 and all bbox fields as 0.
REQ-030 SHALL hold stats_valid and the result registers stable until stats_valid && stats_ready; stats_valid clears the cycle after transfer.
REQ-031 SHALL, when a completion coincides with a pending unaccepted result, overwrite the result, keep stats_valid=1, and set overrun.
REQ-032 SHALL, when a completion coincides with a transfer, load the new result, keep stats_valid=1, and leave overrun unchanged.
REQ-033 SHALL classify a frame as active when motion_count >= count_thresh, with count_thresh sampled at completion.
REQ-034 SHALL use an alarm FSM with states QUIET, ARMING and ALARM, evaluated only at frame completion.
REQ-035 SHALL in QUIET: on an active frame, go to ARMING with run=1, or go directly to ALARM if ALARM_FRAMES=1.
REQ-036 SHALL in ARMING: on an active frame, run++ and go to ALARM when run reaches ALARM_FRAMES; on an inactive frame, go to QUIET.
REQ-037 SHALL in ALARM: count consecutive inactive frames and go to QUIET at CLEAR_FRAMES; an active frame resets that count.
REQ-038 SHALL drive alarm=1 exactly when the state is ALARM.

Reset
REQ-039 SHALL, on rst: clear all outputs to 0, set the frame FSM to IDLE and the alarm FSM to QUIET, and clear counters; rst mid-frame discards the partial frame.

Verification (IMG_W=4, IMG_H=3, ALARM_FRAMES=2, CLEAR_FRAMES=2)
REQ-040 SHALL cover: a 12-pixel frame with motion at (1,0) and (3,2), thresh=5 -> one cycle later stats_valid=1, count=2, bbox x 1..3, y 0..2, bbox_valid=1, alarm=0.
REQ-041 SHALL cover: a frame with no motion -> count=0, bbox_valid=0, all bbox fields 0.
REQ-042 SHALL cover: active frames with thresh=2 and 2 motion pixels each -> frame 1 alarm=0, frame 2 alarm=1; then two zero-motion frames -> alarm=0 after the second.
REQ-043 SHALL cover: stats_ready held 0 across two completions -> second result visible, overrun=1; completion coinciding with ready -> overrun unchanged, stats_valid stays 1.
REQ-044 SHALL cover: sof at pixel 5 -> sync_err pulses once, and the next 12 accepted pixels form the reported frame.
REQ-045 SHALL cover: enable=0 for 3 cycles mid-frame and rst asserted at pixel 6 -> no pixels counted while disabled; after rst, outputs are 0 and stray non-sof pixels are ignored.
